neuron_vec: RTL and testbench



---
 rtl/neuron_pkg.sv | 43 ++++
 rtl/neuron_lane_mult.sv | 31 +++
 rtl/neuron_vec.sv | 148 ++++++++++++++
 tb/tb_neuron_vec.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types and arithmetic for the vector neuron.
// No latency: types, encodings and a combinational round/saturate helper.
// No backpressure: this package holds no logic.
package neuron_pkg;

  // Evaluation sequencing: take beats, drain the multiply/add pipe, present the result.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // act_sel encodings.
  typedef enum logic {
    ACT_RELU   = 1'b0,
    ACT_LINEAR = 1'b1
  } act_t;

  // Working width of the rounding helper; the accumulator must fit inside it.
  localparam int SUM_W = 64;

  // Round half up by frac_w bits, optionally clamp negatives to zero, then
  // saturate to the signed data_w range. The caller truncates to data_w.
  function automatic logic signed [SUM_W-1:0] round_sat(
    input logic signed [SUM_W-1:0] sum,
    input int                      frac_w,
    input int                      data_w,
    input logic                    relu
  );
    logic signed [SUM_W-1:0] r;
    logic signed [SUM_W-1:0] max_v;
    logic signed [SUM_W-1:0] min_v;
    r     = (sum + (64'sd1 <<< (frac_w - 1))) >>> frac_w;
    max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (data_w - 1));
    if (relu && (r < 0)) r = '0;
    if (r > max_v)      r = max_v;
    else if (r < min_v) r = min_v;
    return r;
  endfunction

endpackage

// File: rtl/neuron_lane_mult.sv
// One lane: registered signed multiply with a force-to-zero mask for padding lanes.
// Latency 1 cycle from load to prod.
// No backpressure: prod only updates when load is high and holds otherwise.
//
// Ports: clk, rst (sync active-low), load (beat accepted), zero (lane is padding),
//        a/b (signed operands), prod (registered signed 2*DATA_W product).
module neuron_lane_mult
  import neuron_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       zero,
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [DATA_W-1:0]   b,
  output logic signed [2*DATA_W-1:0] prod
);

  localparam int PW = 2 * DATA_W;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prod <= '0;
    end else if (load) begin
      prod <= zero ? '0 : PW'(a) * PW'(b);
    end
  end

endmodule

// File: rtl/neuron_vec.sv
// Fixed-point neuron: dot product of NUM_INPUTS data/weight pairs, plus bias, ReLU or linear.
// Latency: out_valid rises 3 cycles after the last input beat transfers.
// Backpressure: in_ready is low from the last beat until the result is taken; out_data holds while out_ready is low.
//
// Ports: clk, rst (sync active-low); data_in/weight_in (LANES packed signed, lane 0 in LSBs),
//        bias_in/act_sel (sampled on the first beat), in_valid/in_ready (beat handshake),
//        out_data/out_valid/out_ready (result handshake).
module neuron_vec
  import neuron_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 15,
  parameter int LANES      = 4,
  parameter int NUM_INPUTS = 784,
  parameter int ACC_W      = 48
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES*DATA_W-1:0]   data_in,
  input  logic [LANES*DATA_W-1:0]   weight_in,
  input  logic [DATA_W-1:0]         bias_in,
  input  logic                      act_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int BEATS  = (NUM_INPUTS + LANES - 1) / LANES;
  // Number of real lanes on the final beat; the rest are padding.
  localparam int LAST_N = NUM_INPUTS - (BEATS - 1) * LANES;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW     = 2 * DATA_W;

  if ((NUM_INPUTS < 1) || (FRAC_W < 1) || (FRAC_W >= DATA_W) || (ACC_W > SUM_W) ||
      (ACC_W < 2 * DATA_W + $clog2(NUM_INPUTS))) begin : g_param_err
    $error("neuron_vec: illegal parameter combination");
  end

  state_t                    state;
  state_t                    state_nxt;
  logic [CNT_W-1:0]          beat_cnt;
  logic                      flush_cnt;
  logic                      in_fire;
  logic                      first_beat;
  logic                      last_beat;
  logic                      p_vld;
  logic                      load_sum;
  logic                      load_out;
  logic                      out_fire;
  logic signed [PW-1:0]      prod [LANES];
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   psum;
  logic signed [ACC_W-1:0]   sum_q;
  logic signed [ACC_W-1:0]   bias_sh;
  logic signed [DATA_W-1:0]  bias_q;
  act_t                      act_q;
  logic [DATA_W-1:0]         res;

  assign in_fire    = in_valid & in_ready;
  assign first_beat = (beat_cnt == '0);
  assign last_beat  = (beat_cnt == CNT_W'(BEATS - 1));

  // Stage 1: per-lane registered products.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam bit PAD = (i >= LAST_N);
    neuron_lane_mult #(.DATA_W(DATA_W)) u_mult (
      .clk  (clk),
      .rst  (rst),
      .load (in_fire),
      .zero (last_beat & PAD),
      .a    (data_in[i*DATA_W +: DATA_W]),
      .b    (weight_in[i*DATA_W +: DATA_W]),
      .prod (prod[i])
    );
  end

  // Stage 2 adder tree input: sign-extended lane products.
  always_comb begin
    psum = '0;
    for (int i = 0; i < LANES; i++) begin
      psum = psum + ACC_W'(prod[i]);
    end
  end

  // Bias is aligned to the product binary point (2*FRAC_W fractional bits).
  assign bias_sh = ACC_W'(bias_q) <<< FRAC_W;
  assign res     = DATA_W'(round_sat(SUM_W'(sum_q), FRAC_W, DATA_W, act_q == ACT_RELU));

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // FSM: next state.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_ACCUM: if (in_fire)   state_nxt = last_beat ? ST_FLUSH : ST_ACCUM;
      ST_FLUSH:          if (flush_cnt) state_nxt = ST_OUT;
      ST_OUT:            if (out_fire)  state_nxt = ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs and datapath strobes.
  always_comb begin
    in_ready = rst && ((state == ST_IDLE) || (state == ST_ACCUM));
    load_sum = (state == ST_FLUSH) && flush_cnt;
    load_out = (state == ST_OUT) && !out_valid;
    out_fire = out_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_cnt  <= '0;
      flush_cnt <= 1'b0;
      p_vld     <= 1'b0;
      acc       <= '0;
      sum_q     <= '0;
      bias_q    <= '0;
      act_q     <= ACT_RELU;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      p_vld <= in_fire;
      if (in_fire) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      if (in_fire && first_beat) begin
        bias_q <= bias_in;
        act_q  <= act_t'(act_sel);
      end
      // First FLUSH cycle lets the final products land in acc; second one forms the sum.
      flush_cnt <= (state == ST_FLUSH) ? ~flush_cnt : 1'b0;
      if (out_fire)   acc <= '0;
      else if (p_vld) acc <= acc + psum;
      if (load_sum) sum_q <= acc + bias_sh;
      if (load_out) begin
        out_valid <= 1'b1;
        out_data  <= res;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_neuron_vec.sv
module tb_neuron_vec;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data_in;
  logic [63:0] weight_in;
  logic [15:0] bias_in;
  logic        act_sel;
  logic        vld_a, vld_b, out_ready;
  logic        rdy_a, rdy_b, ov_a, ov_b;
  logic [15:0] od_a, od_b;

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] q_a[$];
  logic [15:0] q_b[$];

  always #5 clk = ~clk;

  neuron_vec #(.DATA_W(16), .FRAC_W(15), .LANES(4), .NUM_INPUTS(8), .ACC_W(48)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .weight_in(weight_in), .bias_in(bias_in),
    .act_sel(act_sel), .in_valid(vld_a), .in_ready(rdy_a), .out_data(od_a),
    .out_valid(ov_a), .out_ready(out_ready));

  neuron_vec #(.DATA_W(16), .FRAC_W(15), .LANES(4), .NUM_INPUTS(6), .ACC_W(48)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .weight_in(weight_in), .bias_in(bias_in),
    .act_sel(act_sel), .in_valid(vld_b), .in_ready(rdy_b), .out_data(od_b),
    .out_valid(ov_b), .out_ready(out_ready));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: every lane carries the same d/w; n real inputs contribute.
  function automatic logic [15:0] model(input logic [15:0] d, input logic [15:0] w,
                                        input logic [15:0] b, input logic act, input int n);
    longint s;
    s = longint'(n) * (longint'($signed(d)) * longint'($signed(w)))
        + (longint'($signed(b)) <<< 15);
    s = (s + 64'sd16384) >>> 15;
    if (!act && s < 0) s = 0;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  // Scoreboards: compare whenever a result handshake is about to happen.
  always @(negedge clk) begin
    if (rst && ov_a && out_ready) begin
      chk("q_a_nonempty", q_a.size() != 0, 1);
      if (q_a.size() != 0) chk("out_a", od_a, q_a.pop_front());
    end
    if (rst && ov_b && out_ready) begin
      chk("q_b_nonempty", q_b.size() != 0, 1);
      if (q_b.size() != 0) chk("out_b", od_b, q_b.pop_front());
    end
  end

  // Entered and left at posedge+1. Later beats carry a different bias/act to
  // show that only the first beat's values are used.
  task automatic send_beats(input bit six, input logic [15:0] d, input logic [15:0] w,
                            input logic [15:0] b, input logic act, input int gap, input int nb);
    bit ok;
    bit rdy;
    for (int bt = 0; bt < nb; bt++) begin
      data_in   = {4{d}};
      weight_in = {4{w}};
      if (six && bt == 1) begin
        data_in[63:32]   = {2{16'h7FFF}};
        weight_in[63:32] = {2{16'h7FFF}};
      end
      bias_in = (bt == 0) ? b : ~b;
      act_sel = (bt == 0) ? act : ~act;
      if (six) vld_b = 1'b1; else vld_a = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        rdy = six ? rdy_b : rdy_a;
        @(posedge clk);
        if (rdy) begin ok = 1'b1; break; end
      end
      #1;
      vld_a = 1'b0;
      vld_b = 1'b0;
      chk("beat_accept", ok, 1);
      if (bt < nb - 1 && gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic run_eval(input bit six, input logic [15:0] d, input logic [15:0] w,
                          input logic [15:0] b, input logic act, input int gap,
                          input bit hold, input logic [15:0] exp);
    int lat;
    if (six) q_b.push_back(exp); else q_a.push_back(exp);
    if (hold) out_ready = 1'b0;
    send_beats(six, d, w, b, act, gap, 2);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (six ? ov_b : ov_a) begin lat = k; break; end
    end
    chk("latency", lat, 3);
    if (hold) begin
      repeat (5) begin
        @(posedge clk); #1;
        chk("hold_data", six ? od_b : od_a, exp);
        chk("hold_valid", six ? ov_b : ov_a, 1);
        chk("hold_in_ready", six ? rdy_b : rdy_a, 0);
      end
      out_ready = 1'b1;
    end
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (!(six ? ov_b : ov_a)) begin lat = k; break; end
    end
    chk("out_taken", lat, 1);
    chk("in_ready_back", six ? rdy_b : rdy_a, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [15:0] d, w, b;
    logic        act;
    bit          six;

    rst = 1'b0; vld_a = 1'b0; vld_b = 1'b0; out_ready = 1'b1;
    data_in = '0; weight_in = '0; bias_in = '0; act_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", rdy_a, 0);
    chk("rst_out_valid", ov_a, 0);
    chk("rst_out_data", od_a, 0);
    chk("rst_out_data_b", od_b, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", rdy_a, 1);
    chk("post_rst_in_ready_b", rdy_b, 1);

    run_eval(0, 16'h4000, 16'h0800, 16'h0000, 1'b0, 0, 0, 16'h2000);
    run_eval(0, 16'h2000, 16'hC000, 16'h0000, 1'b1, 0, 0, 16'h8000);
    run_eval(0, 16'h2000, 16'hC000, 16'h0000, 1'b0, 0, 0, 16'h0000);
    run_eval(0, 16'h4000, 16'h4000, 16'h4000, 1'b1, 0, 0, 16'h7FFF);
    run_eval(0, 16'h4000, 16'h4000, 16'h4000, 1'b0, 0, 0, 16'h7FFF);
    run_eval(1, 16'h4000, 16'h0800, 16'h0000, 1'b0, 0, 0, 16'h1800);
    run_eval(0, 16'h4000, 16'h0800, 16'h0000, 1'b0, 3, 1, 16'h2000);

    // Reset after the first of two beats: that partial result must vanish.
    send_beats(0, 16'h7000, 16'h7000, 16'h1234, 1'b1, 0, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_in_ready", rdy_a, 0);
    chk("mid_rst_out_valid", ov_a, 0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_no_output", ov_a, 0);
    run_eval(0, 16'h4000, 16'h0800, 16'h0000, 1'b0, 0, 0, 16'h2000);

    // Reset while a result is waiting: it must be dropped.
    out_ready = 1'b0;
    send_beats(0, 16'h4000, 16'h0800, 16'h0000, 1'b0, 0, 2);
    repeat (4) @(posedge clk);
    #1;
    chk("pending_valid", ov_a, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("out_rst_valid", ov_a, 0);
    chk("out_rst_data", od_a, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < 8; r++) begin
      six = r[0];
      d   = 16'($urandom);
      w   = 16'($urandom);
      b   = 16'($urandom);
      act = 1'($urandom_range(0, 1));
      run_eval(six, d, w, b, act, r % 3, 0, model(d, w, b, act, six ? 6 : 8));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("q_a_drained", q_a.size(), 0);
    chk("q_b_drained", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
